// File: rtl/cpu_mem_pkg.sv
// Shared types for the CPU memory arbiter: FSM states, transaction owner
// and the default bus widths.
package cpu_mem_pkg;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, load/store and unified-memory signals around mem_arbiter.
// Handshake: a requester holds req and payload until it samples gnt high, and each
// accepted request returns exactly one rvalid (stores too) routed to its owner.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_W-1:0]     if_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic [DATA_W/8-1:0]   d_be;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [DATA_W-1:0]     d_rdata;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_be;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [DATA_W-1:0]     mem_rdata;

    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_addr, d_wdata, d_be,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and load/store onto one single-ported memory,
// data-first with a starvation limit for fetch, one transaction in flight.
module mem_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W   = MEM_ADDR_W,
    parameter int DATA_W   = MEM_DATA_W,
    parameter int MAX_WAIT = 4
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus,
    output arb_state_t   o_state,
    output logic [3:0]   o_starve_cnt
);
    localparam int         BE_W       = DATA_W / 8;
    localparam logic [3:0] STARVE_MAX = 4'(MAX_WAIT);

    arb_state_t        r_state;
    arb_state_t        w_next_state;
    arb_owner_t        r_owner;
    arb_owner_t        w_winner;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;
    logic [BE_W-1:0]   r_be;
    logic [3:0]        r_starve_cnt;
    logic              w_any_req;
    logic              w_arb;
    logic              w_issue;
    logic              w_own_if;
    logic              w_own_d;

    function automatic arb_owner_t arbitrate(input logic fetch_req,
                                             input logic data_req,
                                             input logic [3:0] starve);
        arb_owner_t win;
        win = OWN_D;
        if (fetch_req && (!data_req || starve == STARVE_MAX)) win = OWN_IF;
        return win;
    endfunction

    assign w_any_req = bus.if_req | bus.d_req;
    assign w_winner  = arbitrate(bus.if_req, bus.d_req, r_starve_cnt);

    // Arbitration happens either from IDLE or on the response cycle, so a
    // waiting requester is issued with no dead cycle in between.
    always_comb begin
        w_next_state = r_state;
        w_arb        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_next_state = ISSUE;
                    w_arb        = 1'b1;
                end
            end
            ISSUE: begin
                if (bus.mem_gnt) w_next_state = WAIT_RESP;
            end
            WAIT_RESP: begin
                if (bus.mem_rvalid) begin
                    w_arb        = w_any_req;
                    w_next_state = w_any_req ? ISSUE : IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_owner      <= OWN_IF;
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_wdata      <= '0;
            r_be         <= '0;
            r_starve_cnt <= 4'd0;
        end else if (w_arb) begin
            r_owner <= w_winner;
            if (w_winner == OWN_IF) begin
                r_addr       <= bus.if_addr;
                r_we         <= 1'b0;
                r_wdata      <= '0;
                r_be         <= '1;
                r_starve_cnt <= 4'd0;
            end else begin
                r_addr  <= bus.d_addr;
                r_we    <= bus.d_we;
                r_wdata <= bus.d_wdata;
                r_be    <= bus.d_be;
                // Fetch can only lose below the limit, so this never passes MAX_WAIT.
                if (bus.if_req) r_starve_cnt <= r_starve_cnt + 4'd1;
            end
        end
    end

    assign w_issue  = (r_state == ISSUE);
    assign w_own_if = (r_owner == OWN_IF);
    assign w_own_d  = (r_owner == OWN_D);

    assign bus.mem_req   = w_issue;
    assign bus.mem_we    = w_issue & r_we;
    assign bus.mem_addr  = w_issue ? r_addr  : '0;
    assign bus.mem_wdata = w_issue ? r_wdata : '0;
    assign bus.mem_be    = w_issue ? r_be    : '0;

    assign bus.if_gnt    = w_issue & bus.mem_gnt & w_own_if;
    assign bus.d_gnt     = w_issue & bus.mem_gnt & w_own_d;
    assign bus.if_rvalid = (r_state == WAIT_RESP) & bus.mem_rvalid & w_own_if;
    assign bus.d_rvalid  = (r_state == WAIT_RESP) & bus.mem_rvalid & w_own_d;
    assign bus.if_rdata  = w_own_if ? bus.mem_rdata : '0;
    assign bus.d_rdata   = w_own_d  ? bus.mem_rdata : '0;

    assign o_state      = r_state;
    assign o_starve_cnt = r_starve_cnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch-only, simultaneous requests, starvation,
// memory backpressure, stray responses and asynchronous reset mid-transaction.
module tb_mem_arbiter;
    import cpu_mem_pkg::*;

    localparam int SB_W = 33;

    logic       clk;
    logic       reset;
    arb_state_t state;
    logic [3:0] starve_cnt;

    int errors = 0;
    int checks = 0;
    logic [SB_W-1:0] exp_q[$];
    logic [SB_W-1:0] sb_ent;
    logic [31:0]     mem_model [logic [31:0]];

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .MAX_WAIT (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .o_state      (state),
        .o_starve_cnt (starve_cnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return (a * 32'h0101_0101) ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [255:0] all_outs();
        return {bus.if_gnt, bus.if_rvalid, bus.if_rdata,
                bus.d_gnt, bus.d_rvalid, bus.d_rdata,
                bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be};
    endfunction

    function automatic logic [69:0] mem_payload();
        return {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        bus.if_req     = 1'b0;
        bus.if_addr    = '0;
        bus.d_req      = 1'b0;
        bus.d_we       = 1'b0;
        bus.d_addr     = '0;
        bus.d_wdata    = '0;
        bus.d_be       = '0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
    endtask

    // Entered just after a negedge with the DUT expected in ISSUE. Holds mem_gnt
    // low for 'stall' cycles, grants, then returns the response on the next cycle.
    task automatic serve(input string tag, input logic own_d, input int stall, input logic keep_req);
        logic [69:0] snap;
        logic [31:0] p_addr;
        logic [31:0] p_wdata;
        logic [3:0]  p_be;
        logic        p_we;
        logic [31:0] cur;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        bus.mem_gnt    = 1'b0;
        #1;
        snap = mem_payload();
        check({tag, "_mem_req"}, bus.mem_req, 1'b1);
        if (own_d)
            check({tag, "_payload"}, mem_payload(),
                  {1'b1, bus.d_we, bus.d_addr, bus.d_wdata, bus.d_be});
        else
            check({tag, "_payload"}, {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be},
                  {1'b1, 1'b0, bus.if_addr, 4'hF});
        for (int i = 0; i < stall; i++) begin
            check({tag, "_no_gnt"}, {bus.if_gnt, bus.d_gnt}, 2'b00);
            @(negedge clk);
            #1;
            check({tag, "_stable"}, mem_payload(), snap);
        end
        bus.mem_gnt = 1'b1;
        #1;
        check({tag, "_gnt"}, {bus.if_gnt, bus.d_gnt}, own_d ? 2'b01 : 2'b10);
        if (own_d) exp_q.push_back({1'b1, bus.d_we ? 32'h0 : model_rd(bus.d_addr)});
        else       exp_q.push_back({1'b0, model_rd(bus.if_addr)});
        p_addr  = bus.mem_addr;
        p_we    = bus.mem_we;
        p_wdata = bus.mem_wdata;
        p_be    = bus.mem_be;
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        if (!keep_req) begin
            if (own_d) bus.d_req  = 1'b0;
            else       bus.if_req = 1'b0;
        end
        if (p_we) begin
            cur = model_rd(p_addr);
            for (int b = 0; b < 4; b++)
                if (p_be[b]) cur[b*8 +: 8] = p_wdata[b*8 +: 8];
            mem_model[p_addr] = cur;
            bus.mem_rdata = '0;
        end else begin
            bus.mem_rdata = model_rd(p_addr);
        end
        bus.mem_rvalid = 1'b1;
        #1;
        check({tag, "_rvalid"}, {bus.if_rvalid, bus.d_rvalid}, own_d ? 2'b01 : 2'b10);
    endtask

    task automatic end_resp();
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        #1;
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        #3;
        if (bus.if_rvalid || bus.d_rvalid) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected", {bus.if_rvalid, bus.d_rvalid}, 2'b00);
            end else begin
                sb_ent = exp_q.pop_front();
                check("sb_resp",
                      {bus.d_rvalid, bus.if_rvalid, bus.d_rvalid ? bus.d_rdata : bus.if_rdata},
                      {sb_ent[32], ~sb_ent[32], sb_ent[31:0]});
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        mem_model[32'h4] = 32'h0050_0093;
        reset = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk);
        #1;
        check("rst_outs", all_outs(), '0);
        check("rst_state", state, IDLE);
        check("rst_starve", starve_cnt, 4'd0);
        reset = 1'b1;

        // Fetch only
        @(negedge clk);
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0004;
        #1;
        check("fetch_t0_no_mem_req", bus.mem_req, 1'b0);
        @(negedge clk);
        serve("fetch", 1'b0, 0, 1'b0);
        check("fetch_rdata", bus.if_rdata, 32'h0050_0093);
        check("fetch_d_quiet", {bus.d_gnt, bus.d_rvalid, bus.d_rdata}, '0);
        end_resp();
        check("fetch_idle", state, IDLE);

        // Simultaneous fetch and store: store first, fetch right after its response
        @(negedge clk);
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0008;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h0000_0100;
        bus.d_wdata = 32'hDEAD_BEEF;
        bus.d_be    = 4'hF;
        @(negedge clk);
        serve("simul_store", 1'b1, 0, 1'b0);
        @(negedge clk);
        serve("simul_fetch", 1'b0, 0, 1'b0);
        end_resp();
        check("simul_idle", state, IDLE);

        // Starvation: data held continuously, fetch pending
        @(negedge clk);
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h0000_0200;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_000C;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            serve("starve_d", 1'b1, 0, 1'b1);
            check("starve_cnt_inc", starve_cnt, 4'(i + 1));
        end
        @(negedge clk);
        serve("starve_if", 1'b0, 0, 1'b0);
        check("starve_cnt_clr", starve_cnt, 4'd0);
        @(negedge clk);
        serve("starve_tail", 1'b1, 0, 1'b0);
        check("starve_cnt_hold", starve_cnt, 4'd0);
        end_resp();
        check("starve_idle", state, IDLE);

        // Memory backpressure on a load of the stored word
        @(negedge clk);
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h0000_0100;
        @(negedge clk);
        serve("bp", 1'b1, 3, 1'b0);
        check("bp_rdata", bus.d_rdata, 32'hDEAD_BEEF);
        end_resp();

        // Stray response in IDLE
        @(negedge clk);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h0000_1234;
        #1;
        check("stray_no_rvalid", {bus.if_rvalid, bus.d_rvalid}, 2'b00);
        check("stray_idle", state, IDLE);
        end_resp();

        // Reset during WAIT_RESP
        @(negedge clk);
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0010;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h0000_0020;
        @(negedge clk);
        bus.mem_gnt = 1'b1;
        #1;
        check("rstmid_d_gnt", {bus.if_gnt, bus.d_gnt}, 2'b01);
        check("rstmid_starve", starve_cnt, 4'd1);
        @(negedge clk);
        bus.d_req   = 1'b0;
        bus.mem_gnt = 1'b0;
        #1;
        check("rstmid_wait", state, WAIT_RESP);
        #2;
        reset = 1'b0;
        #1;
        check("rstmid_outs", all_outs(), '0);
        check("rstmid_state", state, IDLE);
        check("rstmid_starve0", starve_cnt, 4'd0);
        bus.if_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h0000_0BAD;
        #1;
        check("late_no_rvalid", {bus.if_rvalid, bus.d_rvalid}, 2'b00);
        check("late_idle", state, IDLE);
        end_resp();
        check("late_still_idle", state, IDLE);

        repeat (2) @(negedge clk);
        check("sb_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-ported memory between the instruction-fetch path and the load/store path of the CPU. Data accesses win by default; a starvation counter forces an instruction fetch through after a bounded number of lost arbitrations. The block allows one outstanding transaction and routes each response back to its owner. It sits between `pc_counter`/`imem`-side fetch logic, the `dmem` access path, and a unified memory.

## Interface
Parameters:
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width. Must be a multiple of 8.
- `MAX_WAIT`, 4: number of consecutive arbitrations fetch may lose before it must win. Range 1..15.

Ports:
- `clk`  in  1: clock. All logic is rising-edge.
- `reset`  in  1: asynchronous reset, active-low. Fixed; not a parameter.
- `if_req`  in  1: fetch request.
- `if_addr`  in  ADDR_W: fetch address.
- `if_gnt`  out  1: fetch request accepted by memory.
- `if_rvalid`  out  1: fetch response valid.
- `if_rdata`  out  DATA_W: fetch response data.
- `d_req`  in  1: data request.
- `d_we`  in  1: 1 = store, 0 = load.
- `d_addr`  in  ADDR_W: data address.
- `d_wdata`  in  DATA_W: store data.
- `d_be`  in  DATA_W/8: byte enables.
- `d_gnt`, `d_rvalid`  out  1: same meaning as the `if_` versions.
- `d_rdata`  out  DATA_W: load data.
- `mem_req`, `mem_we`  out  1: memory request and write flag.
- `mem_addr`  out  ADDR_W: memory address.
- `mem_wdata`  out  DATA_W: memory write data.
- `mem_be`  out  DATA_W/8: memory byte enables.
- `mem_gnt`  in  1: memory accepts the request.
- `mem_rvalid`  in  1: memory response valid. Memory also returns `mem_rvalid` for writes, as an acknowledgement.
- `mem_rdata`  in  DATA_W: memory response data.

## Operation
- FSM states: IDLE, ISSUE, WAIT_RESP.
  - IDLE → ISSUE when any request is present (arbitrate in that cycle).
  - ISSUE → WAIT_RESP on `mem_gnt`.
  - WAIT_RESP → ISSUE on `mem_rvalid` if any request is present (re-arbitrate in that cycle).
  - WAIT_RESP → IDLE on `mem_rvalid` if no request is present.
- Arbitration:
  - Data wins over fetch unless `starve_cnt == MAX_WAIT`, in which case fetch wins.
  - `starve_cnt` (4 bits) increments when fetch is requesting and loses; it clears when fetch wins.
  - It holds otherwise and never exceeds `MAX_WAIT`.
- On an arbitration win, register the owner and the winner's `addr`, `we`, `wdata` and `be`. ISSUE drives the `mem_*` outputs from these registers only.
- For a fetch, `mem_we = 0` and `mem_be` is all ones.
- `x_gnt = mem_req & mem_gnt & (owner == x)`, a one-cycle pulse.
- Requester rules:
  - The requester holds `req` and its payload until it sees `gnt`.
  - It may reassert `req` the cycle after `gnt`.
  - A request during WAIT_RESP is a new request.
- `x_rvalid = (state == WAIT_RESP) & mem_rvalid & (owner == x)`.
- `x_rdata = mem_rdata` when the owner matches, else 0. This is combinational pass-through.
- Boundary conditions:
  - `mem_rvalid` in IDLE or ISSUE is ignored.
  - `mem_gnt` outside ISSUE is ignored.
  - A request that drops before `gnt` is a protocol violation and is not checked.
- Reset, including reset mid-transaction:
  - State → IDLE; `starve_cnt`, owner and payload registers → 0.
  - An in-flight response is discarded, because memory shares the same reset.

## Timing
- Reset values: every output is 0.
- Latency: a request seen in IDLE at cycle t gives `mem_req` at t+1. With an immediate `mem_gnt`, `x_gnt` is at t+1.
- The earliest `mem_rvalid` is the cycle after `mem_gnt` (t+2). `x_rvalid` appears in that same cycle.
- Back-to-back: a request present on the `mem_rvalid` cycle gives `mem_req` on the next cycle. Sustained throughput is one transaction per 2 cycles.
- While `mem_gnt` is low in ISSUE, `mem_req` and every `mem_*` payload bit stay stable.
- Simultaneous `if_req` and `d_req` in the arbitration cycle are resolved by the priority rule above. No request is lost.

## Structure
- Shared package `cpu_mem_pkg`:
  - `arb_state_t` enum {IDLE, ISSUE, WAIT_RESP}.
  - `arb_owner_t` enum {OWN_IF, OWN_D}.
  - `MEM_ADDR_W` and `MEM_DATA_W` constants.
- Single module with no sub-modules. The arbitration decision is one combinational function inside it.

## Test plan
- Fetch only:
  - Stimulus: `if_req` with `if_addr = 0x0000_0004`; `mem_gnt` immediate; `mem_rdata = 0x0050_0093` the next cycle.
  - Required: `if_gnt` at t+1; `if_rvalid` with `0x0050_0093` at t+2; all `d_*` outputs stay 0.
- Simultaneous requests:
  - Stimulus: `if_req` and a `d_req` store (`0x100`, `0xDEAD_BEEF`, `be = 0xF`) in the same cycle.
  - Required: memory sees the store first with `mem_we = 1`; the fetch is issued the cycle after the store's `mem_rvalid`.
- Starvation:
  - Stimulus: `MAX_WAIT = 4`; `d_req` held continuously; `if_req` pending throughout.
  - Required: data wins 4 arbitrations; the 5th is a fetch; `starve_cnt` then reads 0.
- Memory backpressure:
  - Stimulus: `mem_gnt` held low for 3 cycles in ISSUE.
  - Required: `mem_req = 1` and the payload are constant; no `gnt` pulse; `x_gnt` appears in the cycle `mem_gnt` rises.
- Stray and reset:
  - Stimulus: `mem_rvalid` pulsed in IDLE; then reset asserted during WAIT_RESP.
  - Required: no `x_rvalid` from the stray pulse; on reset, all outputs are 0 immediately (asynchronous) and state is IDLE; a late `mem_rvalid` after release is ignored.
